lcd_text_controller: RTL and testbench
======================================

LCD_TEXT_CONTROLLER -- requirements
Module: lcd_text_controller

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000, meaning clk cycles per LCD step tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter COLS, default 16, meaning characters per LCD line (1..40).
REQ-003 SHALL have parameter ROWS, default 2, meaning LCD lines driven (1 or 2).
REQ-004 SHALL have parameter POWERUP_TICKS, default 20, meaning ticks waited after reset before the first command.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en  input  1  one-cycle strobe that writes wr_char into the shadow buffer.
REQ-008 SHALL have port wr_row  input  1  target line (0 = top).
REQ-009 SHALL have port wr_col  input  6  target column.
REQ-010 SHALL have port wr_char  input  8  ASCII code.
REQ-011 SHALL have port clr_req  input  1  one-cycle strobe that fills the shadow buffer with spaces (0x20).
REQ-012 SHALL have port busy  output  1  high while a buffer fill is in progress; writes are ignored.
REQ-013 SHALL have port init_done  output  1  high once the init sequence has completed; stays high until reset.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last character of a refresh frame is strobed.
REQ-015 SHALL have ports rs, rw, en (output, 1 each) and data (output, 8), the HD44780 8-bit bus.

Function
REQ-016 SHALL generate tick as a one-cycle pulse every TICK_CYCLES clk cycles from a free-running counter; the FSM advances only on tick.
REQ-017 SHALL hold a COLS*ROWS byte shadow buffer; an accepted write updates the entry on the next clk edge.
REQ-018 SHALL ignore wr_en when wr_row >= ROWS, wr_col >= COLS, or busy=1; it SHALL NOT set dirty in those cases.
REQ-019 SHALL run a fill on clr_req (or on reset release): write 0x20 to one entry per clk cycle, busy=1 for exactly COLS*ROWS cycles, and set dirty at the end.
REQ-020 SHALL give clr_req priority over wr_en when both are asserted in the same cycle; clr_req during busy restarts the fill at entry 0.
REQ-021 SHALL send each LCD byte in two ticks: a SETUP tick that drives rs/data with en=0, then an ENABLE tick with en=1 for exactly one tick period and rs/data unchanged; rw SHALL always be 0.
REQ-022 SHALL step through the FSM states PWRUP (POWERUP_TICKS ticks), FUNC (0x38 if ROWS=2, else 0x30), DISP (0x0C), ENTRY (0x06), CLEAR (0x01), CLRWAIT (2 ticks), then IDLE with init_done=1.
REQ-023 SHALL in IDLE, when dirty=1 and busy=0, clear dirty and start a frame: for each row r, command 0x80 (r=0) or 0xC0 (r=1), then COLS data bytes (rs=1) read from the buffer at SETUP time, in column order.
REQ-024 SHALL, after the last byte's ENABLE tick, pulse frame_done and return to IDLE; a write accepted during a frame re-sets dirty and causes exactly one further frame.
REQ-025 SHALL take ROWS*(COLS+1)*2 ticks per frame, i.e. 68 ticks for 16x2.
REQ-026 SHALL NOT start a frame while busy=1; dirty stays pending until the fill completes.

Reset
REQ-027 SHALL on rst low immediately drive rs=0, rw=0, en=0, data=0x00, init_done=0, frame_done=0, dirty=0, tick counter=0, and FSM state=PWRUP.
REQ-028 SHALL start the space-fill (busy=1) on the first clk edge after rst deasserts; reset asserted mid-frame SHALL drop en low asynchronously and abandon the frame.

Verification (TICK_CYCLES=4, POWERUP_TICKS=3, COLS=16, ROWS=2)
REQ-029 SHALL check reset release -> busy high for 32 cycles; bytes 0x38, 0x0C, 0x06, 0x01 each shown with a one-tick en pulse; init_done=1; first frame shows 0x80 plus 16x 0x20, then 0xC0 plus 16x 0x20, then frame_done.
REQ-030 SHALL check a write of row 1, col 15, 'Z' while IDLE -> the next frame's last data byte is 0x5A with rs=1, and frame_done pulses once.
REQ-031 SHALL check writes to col 16 and to row 1 with ROWS=1 -> buffer unchanged and no frame started.
REQ-032 SHALL check a write during frame byte 5 -> that frame completes unchanged and exactly one extra frame follows.
REQ-033 SHALL check clr_req and wr_en in the same cycle -> the write is dropped, busy=1 for 32 cycles, and the frame shows all 0x20.
REQ-034 SHALL check rst low asserted during an ENABLE tick -> en=0 before the next clk edge; full init reruns after release.

Source files
------------

// File: rtl/lcd_text_controller.sv
// lcd_text_controller: HD44780 8-bit text refresher fed from a COLS x ROWS shadow buffer
// Ports: clk, rst (async active-low); wr_en/wr_row/wr_col/wr_char write one character;
// clr_req space-fills the buffer (busy high meanwhile); init_done after the LCD init
// sequence; frame_done pulses at the end of each refresh; rs/rw/en/data drive the LCD bus.
module lcd_text_controller #(
  parameter int TICK_CYCLES   = 50000,
  parameter int COLS          = 16,
  parameter int ROWS          = 2,
  parameter int POWERUP_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic       clr_req,
  output logic       busy,
  output logic       init_done,
  output logic       frame_done,
  output logic       rs,
  output logic       rw,
  output logic       en,
  output logic [7:0] data
);
  localparam int N  = COLS * ROWS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam int PW = POWERUP_TICKS > 1 ? $clog2(POWERUP_TICKS) : 1;
  localparam logic [7:0] FUNC_CMD = ROWS == 2 ? 8'h38 : 8'h30;

  typedef enum logic [3:0] {
    S_PWRUP, S_FUNC, S_DISP, S_ENTRY, S_CLEAR, S_CLRWAIT, S_IDLE, S_ADDR, S_DATA
  } state_t;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          r_start, r_busy, r_dirty;
  logic [IW-1:0] r_fill_idx;
  logic [7:0]    r_buf [2**IW];
  logic [IW-1:0] w_wr_idx, w_rd_idx;
  logic          w_wr_ok, w_fill_last, w_frame_start;

  state_t        r_state, w_state;
  logic          r_phase, w_phase;
  logic [PW-1:0] r_cnt, w_cnt;
  logic          r_row, w_row;
  logic [5:0]    r_col, w_col;
  logic          r_rs, w_rs, r_en, w_en;
  logic [7:0]    r_data, w_data, w_byte;
  logic          r_init_done, w_init_done, r_frame_done, w_frame_done;
  logic          w_col_last, w_row_last;

  assign w_tick = r_tick_cnt == TW'(TICK_CYCLES - 1);

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_tick_cnt <= '0;
    else      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

  assign w_wr_ok     = wr_en & ~clr_req & ~r_busy & ({31'b0, wr_row} < ROWS) & ({26'b0, wr_col} < COLS);
  assign w_wr_idx    = IW'(wr_row ? COLS : 0) + IW'(wr_col);
  assign w_rd_idx    = IW'(r_row ? COLS : 0) + IW'(r_col);
  assign w_fill_last = r_busy & (r_fill_idx == IW'(N - 1));

  // r_start makes the fill begin on the first edge after reset release.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_start    <= 1'b1;
      r_busy     <= 1'b0;
      r_fill_idx <= '0;
      r_dirty    <= 1'b0;
    end else begin
      if (clr_req | r_start) begin
        r_start    <= 1'b0;
        r_busy     <= 1'b1;
        r_fill_idx <= '0;
      end else if (r_busy) begin
        r_fill_idx <= r_fill_idx + 1'b1;
        r_busy     <= ~w_fill_last;
      end
      r_dirty <= (w_fill_last & ~clr_req) | w_wr_ok | (r_dirty & ~w_frame_start);
    end

  always_ff @(posedge clk)
    if (r_busy)       r_buf[r_fill_idx] <= 8'h20;
    else if (w_wr_ok) r_buf[w_wr_idx]   <= wr_char;

  assign w_col_last = {26'b0, r_col} == COLS - 1;
  assign w_row_last = {31'b0, r_row} == ROWS - 1;
  assign w_byte = r_state == S_FUNC  ? FUNC_CMD :
                  r_state == S_DISP  ? 8'h0C :
                  r_state == S_ENTRY ? 8'h06 :
                  r_state == S_CLEAR ? 8'h01 :
                  r_state == S_ADDR  ? (r_row ? 8'hC0 : 8'h80) : r_buf[w_rd_idx];

  // Byte states: phase 0 is the SETUP tick, phase 1 raises en and advances;
  // the following state's first tick lowers en again.
  always_comb begin
    w_state       = r_state;
    w_phase       = r_phase;
    w_cnt         = r_cnt;
    w_row         = r_row;
    w_col         = r_col;
    w_rs          = r_rs;
    w_en          = r_en;
    w_data        = r_data;
    w_init_done   = r_init_done;
    w_frame_done  = 1'b0;
    w_frame_start = 1'b0;
    if (w_tick)
      case (r_state)
        S_PWRUP: begin
          w_cnt   = r_cnt == PW'(POWERUP_TICKS - 1) ? '0 : r_cnt + 1'b1;
          w_state = r_cnt == PW'(POWERUP_TICKS - 1) ? S_FUNC : S_PWRUP;
        end
        S_FUNC, S_DISP, S_ENTRY, S_CLEAR, S_ADDR, S_DATA:
          if (!r_phase) begin
            w_rs    = r_state == S_DATA;
            w_data  = w_byte;
            w_en    = 1'b0;
            w_phase = 1'b1;
          end else begin
            w_en    = 1'b1;
            w_phase = 1'b0;
            w_cnt   = '0;
            case (r_state)
              S_FUNC:  w_state = S_DISP;
              S_DISP:  w_state = S_ENTRY;
              S_ENTRY: w_state = S_CLEAR;
              S_CLEAR: w_state = S_CLRWAIT;
              S_ADDR: begin
                w_state = S_DATA;
                w_col   = '0;
              end
              default: begin
                w_col   = w_col_last ? '0 : r_col + 1'b1;
                w_row   = w_col_last & ~w_row_last ? 1'b1 : r_row;
                w_state = ~w_col_last ? S_DATA : w_row_last ? S_IDLE : S_ADDR;
              end
            endcase
          end
        S_CLRWAIT: begin
          w_en        = 1'b0;
          w_cnt       = r_cnt + 1'b1;
          w_state     = r_cnt == PW'(1) ? S_IDLE : S_CLRWAIT;
          w_init_done = r_init_done | (r_cnt == PW'(1));
        end
        S_IDLE: begin
          w_en         = 1'b0;
          w_frame_done = r_en;
          if (r_dirty & ~r_busy & ~clr_req) begin
            w_frame_start = 1'b1;
            w_state       = S_ADDR;
            w_row         = 1'b0;
            w_col         = '0;
          end
        end
        default: ;
      endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state      <= S_PWRUP;
      r_phase      <= 1'b0;
      r_cnt        <= '0;
      r_row        <= 1'b0;
      r_col        <= '0;
      r_rs         <= 1'b0;
      r_en         <= 1'b0;
      r_data       <= 8'h00;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_phase      <= w_phase;
      r_cnt        <= w_cnt;
      r_row        <= w_row;
      r_col        <= w_col;
      r_rs         <= w_rs;
      r_en         <= w_en;
      r_data       <= w_data;
      r_init_done  <= w_init_done;
      r_frame_done <= w_frame_done;
    end

  assign busy       = r_busy;
  assign init_done  = r_init_done;
  assign frame_done = r_frame_done;
  assign rs         = r_rs;
  assign rw         = 1'b0;
  assign en         = r_en;
  assign data       = r_data;
endmodule

// File: tb/tb_lcd_text_controller.sv
// tb_lcd_text_controller: directed checks of init, refresh frames, write filtering, fill and reset
module tb_lcd_text_controller;
  localparam int TC = 4;
  logic clk = 0, rst = 0;
  logic wr_en = 0, wr_row = 0, clr_req = 0;
  logic [5:0] wr_col = 0;
  logic [7:0] wr_char = 0;
  logic busy, init_done, frame_done, rs, rw, en;
  logic [7:0] data;
  logic wr1_en = 0, wr1_row = 0, clr1 = 0;
  logic [5:0] wr1_col = 0;
  logic [7:0] wr1_char = 0;
  logic busy1, init_done1, frame_done1, rs1, rw1, en1;
  logic [7:0] data1;
  int checks = 0, errors = 0, bad = 0, cyc = 0, fd_cnt = 0, fd_cyc = 0, fd1 = 0, en_len = 0;
  logic prev_en = 0, prev_fd = 0, prev_en1 = 0;
  logic [8:0] hold;
  logic [8:0] q[$];
  logic [8:0] q1[$];
  int qt[$];

  lcd_text_controller #(.TICK_CYCLES(TC), .COLS(16), .ROWS(2), .POWERUP_TICKS(3)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .clr_req(clr_req), .busy(busy), .init_done(init_done), .frame_done(frame_done),
    .rs(rs), .rw(rw), .en(en), .data(data));

  lcd_text_controller #(.TICK_CYCLES(TC), .COLS(16), .ROWS(1), .POWERUP_TICKS(3)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr1_en), .wr_row(wr1_row), .wr_col(wr1_col), .wr_char(wr1_char),
    .clr_req(clr1), .busy(busy1), .init_done(init_done1), .frame_done(frame_done1),
    .rs(rs1), .rw(rw1), .en(en1), .data(data1));

  always #5 clk = ~clk;

  // Bus monitor: logs {rs,data} at each en rise, checks en width, bus stability and pulse shape.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      en_len = 0;
      prev_en = 0;
      prev_fd = 0;
      prev_en1 = 0;
    end else begin
      if (rw !== 1'b0 || rw1 !== 1'b0) bad++;
      if (en && !prev_en) begin
        q.push_back({rs, data});
        qt.push_back(cyc);
        hold = {rs, data};
        en_len = 1;
      end else if (en) begin
        en_len++;
        if ({rs, data} !== hold) bad++;
      end else if (prev_en && en_len != TC) bad++;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        if (prev_fd) bad++;
      end
      if (en1 && !prev_en1) q1.push_back({rs1, data1});
      if (frame_done1) fd1++;
      prev_en = en;
      prev_fd = frame_done;
      prev_en1 = en1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] qa(input int i);
    return i < q.size() ? q[i] : 9'h1FF;
  endfunction

  function automatic logic [8:0] q1a(input int i);
    return i < q1.size() ? q1[i] : 9'h1FF;
  endfunction

  task automatic write(input logic row, input logic [5:0] col, input logic [7:0] ch);
    @(negedge clk);
    wr_en = 1; wr_row = row; wr_col = col; wr_char = ch;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic write1(input logic row, input logic [5:0] col, input logic [7:0] ch);
    @(negedge clk);
    wr1_en = 1; wr1_row = row; wr1_col = col; wr1_char = ch;
    @(negedge clk);
    wr1_en = 0;
  endtask

  task automatic meas_busy(input string tag);
    int n = 0, w = 0;
    while (!busy && w < 20) begin @(negedge clk); w++; end
    while (busy && n < 200) begin n++; @(negedge clk); end
    check(tag, n, 32);
  endtask

  task automatic wait_fd(input int target, input string tag);
    int n = 0;
    while (fd_cnt < target && n < 5000) begin @(negedge clk); n++; end
    check(tag, fd_cnt, target);
  endtask

  task automatic check_init(input string tag);
    check({tag, "_sz"}, q.size(), 38);
    check({tag, "_func"}, qa(0), 9'h038);
    check({tag, "_disp"}, qa(1), 9'h00C);
    check({tag, "_entry"}, qa(2), 9'h006);
    check({tag, "_clear"}, qa(3), 9'h001);
    check({tag, "_done"}, init_done, 1);
  endtask

  initial begin
    int ns, n;
    repeat (3) @(negedge clk);
    check("rst_rs", rs, 0);
    check("rst_rw", rw, 0);
    check("rst_en", en, 0);
    check("rst_data", data, 0);
    check("rst_init", init_done, 0);
    check("rst_fd", frame_done, 0);
    check("rst_busy", busy, 0);
    rst = 1;
    meas_busy("busy_init");
    wait_fd(1, "fd_init");
    check_init("init");
    check("f1_addr0", qa(4), 9'h080);
    check("f1_addr1", qa(21), 9'h0C0);
    ns = 0;
    for (int i = 0; i < 16; i++) ns += (qa(5 + i) != 9'h120) + (qa(22 + i) != 9'h120);
    check("f1_spaces", ns, 0);
    check("frame_len", qt.size() > 4 ? fd_cyc - qt[4] : 0, 268);
    check("u1_func", q1a(0), 9'h030);
    check("u1_sz", q1.size(), 21);
    check("u1_fd", fd1, 1);
    repeat (300) @(negedge clk);
    check("f1_once", fd_cnt, 1);

    q.delete(); fd_cnt = 0;
    write(1, 15, "Z");
    wait_fd(1, "fd_z");
    check("z_sz", q.size(), 34);
    check("z_last", qa(33), 9'h15A);
    check("z_r0c15", qa(16), 9'h120);
    repeat (200) @(negedge clk);
    check("z_once", fd_cnt, 1);

    q.delete(); fd_cnt = 0;
    write(0, 16, "A");
    repeat (400) @(negedge clk);
    check("col16_nofd", fd_cnt, 0);
    check("col16_noq", q.size(), 0);
    write(0, 0, "B");
    wait_fd(1, "fd_b");
    check("b_c0", qa(1), 9'h142);
    check("col16_alias", qa(18), 9'h120);
    check("z_kept", qa(33), 9'h15A);
    q1.delete(); fd1 = 0;
    write1(1, 0, "Q");
    repeat (400) @(negedge clk);
    check("row1_nofd", fd1, 0);
    write1(0, 1, "R");
    n = 0;
    while (fd1 < 1 && n < 2000) begin @(negedge clk); n++; end
    check("u1_fd_r", fd1, 1);
    check("u1_sz_r", q1.size(), 17);
    check("u1_c0", q1a(1), 9'h120);
    check("u1_c1", q1a(2), 9'h152);

    q.delete(); fd_cnt = 0;
    write(0, 0, "C");
    n = 0;
    while (q.size() < 6 && n < 2000) begin @(negedge clk); n++; end
    check("mid_reach", q.size(), 6);
    write(0, 2, "D");
    wait_fd(2, "fd_mid");
    repeat (400) @(negedge clk);
    check("mid_two", fd_cnt, 2);
    check("mid_sz", q.size(), 68);
    check("mid_f1c0", qa(1), 9'h143);
    check("mid_f1c2", qa(3), 9'h120);
    check("mid_f2c0", qa(35), 9'h143);
    check("mid_f2c2", qa(37), 9'h144);

    q.delete(); fd_cnt = 0;
    @(negedge clk);
    clr_req = 1; wr_en = 1; wr_row = 0; wr_col = 5; wr_char = "E";
    @(negedge clk);
    clr_req = 0; wr_en = 0;
    meas_busy("busy_clr");
    wait_fd(1, "fd_clr");
    check("clr_sz", q.size(), 34);
    check("clr_a0", qa(0), 9'h080);
    check("clr_a1", qa(17), 9'h0C0);
    ns = 0;
    for (int i = 0; i < 16; i++) ns += (qa(1 + i) != 9'h120) + (qa(18 + i) != 9'h120);
    check("clr_spaces", ns, 0);

    q.delete(); fd_cnt = 0;
    write(0, 0, "X");
    n = 0;
    while (!en && n < 2000) begin @(negedge clk); n++; end
    check("pre_rst_en", en, 1);
    #1 rst = 0;
    #1;
    check("arst_en", en, 0);
    check("arst_data", data, 0);
    check("arst_init", init_done, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    q.delete(); fd_cnt = 0;
    meas_busy("busy_rerun");
    wait_fd(1, "fd_rerun");
    check_init("rerun");
    check("en_shape", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
